// File: rtl/cache_refill_ctrl.sv
// Cache miss handler: optional dirty-victim writeback, then critical-word-first line fill.
// Optional memory watchdog enabled by defining REFILL_TIMEOUT_EN.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 miss_req,
  input  logic [ADDR_WIDTH-1:0]                miss_addr,
  input  logic                                 victim_dirty,
  input  logic [ADDR_WIDTH-1:0]                victim_addr,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] victim_data,
  output logic                                 busy,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_ack,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic                                 fill_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0]    fill_word,
  output logic [DATA_WIDTH-1:0]                fill_data,
  output logic                                 done,
  output logic                                 err
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned LINE_W = DATA_WIDTH * WORDS_PER_LINE;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [IDX_W-1:0]        start_q, start_d;
  logic [ADDR_WIDTH-1:0]   vaddr_q, vaddr_d;
  logic [LINE_W-1:0]       vdata_q, vdata_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    fill_we_q, fill_we_d;
  logic [IDX_W-1:0]        fill_word_q, fill_word_d;
  logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;

  logic [IDX_W-1:0]        fill_idx;
  logic [DATA_WIDTH-1:0]   victim_word;
  logic                    last_word;
  logic                    timeout;

  // Critical-word-first index wraps naturally because the line size is a power of two.
  assign fill_idx  = start_q + cnt_q;
  assign last_word = (cnt_q == LAST_IDX);

  always_comb begin
    victim_word = '0;
    for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
      if (cnt_q == IDX_W'(i)) begin
        victim_word = vdata_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef REFILL_TIMEOUT_EN
  localparam int unsigned WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W   = (WD_RAW < 8) ? 8 : WD_RAW;

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts consecutive stalled request cycles; the limit cycle itself raises err.
  always_comb begin
    wd_d    = '0;
    timeout = 1'b0;
    if (mem_req && !mem_ack) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    start_d     = start_q;
    vaddr_d     = vaddr_q;
    vdata_d     = vdata_q;
    cnt_d       = cnt_q;
    fill_we_d   = 1'b0;
    fill_word_d = '0;
    fill_data_d = '0;

    unique case (state_q)
      StIdle: begin
        if (miss_req) begin
          base_d  = miss_addr & ~LINE_MASK;
          start_d = miss_addr[IDX_W+1:2];
          vaddr_d = victim_addr;
          vdata_d = victim_data;
          cnt_d   = '0;
          state_d = victim_dirty ? StWb : StFill;
        end
      end
      StWb: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (mem_ack) begin
          cnt_d = last_word ? '0 : cnt_q + 1'b1;
          if (last_word) begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (mem_ack) begin
          fill_we_d   = 1'b1;
          fill_word_d = fill_idx;
          fill_data_d = mem_rdata;
          cnt_d       = cnt_q + 1'b1;
          if (last_word) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      start_q     <= '0;
      vaddr_q     <= '0;
      vdata_q     <= '0;
      cnt_q       <= '0;
      fill_we_q   <= 1'b0;
      fill_word_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      start_q     <= start_d;
      vaddr_q     <= vaddr_d;
      vdata_q     <= vdata_d;
      cnt_q       <= cnt_d;
      fill_we_q   <= fill_we_d;
      fill_word_q <= fill_word_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    mem_req   = (state_q == StWb) || (state_q == StFill);
    mem_we    = (state_q == StWb);
    mem_addr  = '0;
    mem_wdata = '0;
    done      = (state_q == StDone);
    err       = timeout;
    if (state_q == StWb) begin
      mem_addr  = vaddr_q + ADDR_WIDTH'({cnt_q, 2'b00});
      mem_wdata = victim_word;
    end else if (state_q == StFill) begin
      mem_addr = base_q + ADDR_WIDTH'({fill_idx, 2'b00});
    end
  end

  assign fill_we   = fill_we_q;
  assign fill_word = fill_word_q;
  assign fill_data = fill_data_q;

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss handler that sits directly downstream of the reconfigurable cache core. On a cache miss it writes back a dirty victim line to main memory, then fetches the missing line critical-word-first. Each returned word is handed back to the cache data array. It drives the cache's ready indication and uses a req/ack handshake toward main memory.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, memory and cache word width
WORDS_PER_LINE, 4, words per line; power of two; 4 matches the 4-bit byte offset
TIMEOUT_CYCLES, 255, watchdog limit; used only with REFILL_TIMEOUT_EN

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
miss_req  in  1  cache reports a miss; sampled only in IDLE
miss_addr  in  ADDR_WIDTH  byte address that missed
victim_dirty  in  1  victim line must be written back
victim_addr  in  ADDR_WIDTH  line base address of the victim
victim_data  in  DATA_WIDTH*WORDS_PER_LINE  victim line; word 0 in the LSBs
busy  out  1  refill in progress; cache o_ready = !busy
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  word-aligned memory address
mem_wdata  out  DATA_WIDTH  write data
mem_ack  in  1  memory accepted the request; for reads, mem_rdata is valid in the same cycle
mem_rdata  in  DATA_WIDTH  read data
fill_we  out  1  write one word into the cache line
fill_word  out  log2(WORDS_PER_LINE)  word index within the line
fill_data  out  DATA_WIDTH  word to write
done  out  1  one-cycle pulse: line complete, cache may retry the access
err  out  1  one-cycle pulse on timeout; tied 0 when the feature is off

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; all outputs = 0; all counters and latches cleared. Reset asserted mid-refill abandons the transfer immediately. No partial-line completion and no done pulse.
- Line base = miss_addr with the low log2(WORDS_PER_LINE*4) bits cleared. start = miss_addr[log2(WORDS_PER_LINE)+1:2].
- IDLE: when miss_req = 1, latch miss_addr, victim_addr, victim_data and victim_dirty, then assert busy on the next edge.
  - Next state is WB if victim_dirty = 1, otherwise FILL.
  - miss_req while busy is ignored; the cache holds its request.
- WB: words 0..WORDS_PER_LINE-1 are written in ascending order.
  - mem_req = 1, mem_we = 1, mem_addr = victim_addr + 4*k, mem_wdata = victim word k.
  - These outputs are held stable until mem_ack is sampled high. k then advances on the same edge.
  - After the last ack: go to FILL, with mem_req held high and no idle cycle.
- FILL: reads are issued critical-word-first.
  - Word index w = (start + k) mod WORDS_PER_LINE, wrapping at the line end.
  - mem_req = 1, mem_we = 0, mem_addr = base + 4*w.
  - On each edge with mem_ack = 1: register fill_we = 1, fill_word = w, fill_data = mem_rdata, visible in the following cycle. fill_we is low in all other cycles.
  - On the last ack: mem_req drops on that edge and the state goes to DONE.
- DONE: lasts one cycle, coinciding with the final fill_we. done = 1 and busy = 1. Then go to IDLE with busy = 0.
- Latency, clean line with mem_ack tied high: miss_req at cycle 0; mem_req in cycles 1..4; fill_we in cycles 2..5; done in cycle 5; busy low in cycle 6.
- mem_ack while mem_req = 0 is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH.

Optional Feature:
REFILL_TIMEOUT_EN
- Defined:
  - An 8-bit+ watchdog counts consecutive cycles with mem_req = 1 and mem_ack = 0.
  - When the count reaches TIMEOUT_CYCLES: drop mem_req, pulse err for one cycle, return to IDLE with busy = 0, no done pulse.
  - The watchdog clears on every ack.
- Undefined: no counter; the block waits on memory indefinitely; err is constant 0.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with random inputs -> busy, mem_req, fill_we, done, err all 0. Release reset -> still 0 until miss_req.
- Clean miss, miss_addr = 0x0000_00C8, mem_ack tied 1, mem_rdata = address -> mem_addr sequence 0xC8, 0xCC, 0xC0, 0xC4; fill_word sequence 2, 3, 0, 1; done in cycle 5.
- Dirty miss, victim_addr = 0x7000_00C0, victim_data words A0..A3, miss_addr = 0x0010_00C0 -> 4 writes to 0x7000_00C0..CC carrying A0..A3, then reads starting at 0x0010_00C0; done after 8 acks.
- Memory stall: mem_ack low for 3 cycles per word -> mem_addr and mem_wdata stable during each stall; exactly 4 fill_we pulses; no duplicated words.
- Reset asserted during FILL after 2 acks -> all outputs 0 immediately. Following clean miss completes normally with 4 fills.
- With REFILL_TIMEOUT_EN and TIMEOUT_CYCLES = 10: mem_ack held 0 -> err pulses on the 10th stalled cycle, busy = 0 next cycle, done never asserted.
